aes_msg_loader: RTL and testbench
=================================

Name: aes_msg_loader

Overview:
- Upstream feeder for the AES operand mux: assembles a 256-bit message operand from a narrow word stream and presents it with a valid flag.
- Output m_o/mvalid_o connects directly to the mux message inputs m_i/mvalid_i.
- Accepts words over a valid/ready handshake, zero-pads short messages, and holds the assembled block until the consumer pulses consume_i.

Parameters:
- WORD_W, 32, width of one input word in bits.
- N_WORDS, 8, words per message block. WORD_W*N_WORDS must equal 256.
- CNT_W, 4, width of the word index/length fields. Must be at least clog2(N_WORDS+1).

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- clear_i  in  1  synchronous abort; discards any partial or held block.
- data_i  in  WORD_W  input word.
- valid_i  in  1  data_i is valid.
- last_i  in  1  qualifies data_i as the final word of the message; meaningful only with valid_i.
- ready_o  out  1  loader accepts a word this cycle.
- consume_i  in  1  downstream has taken the held block.
- m_o  out  WORD_W*N_WORDS  assembled message. The first word received lands in the top bits.
- mvalid_o  out  1  m_o is complete and stable.
- len_o  out  CNT_W  number of words actually received into the held block (1..N_WORDS).
- short_o  out  1  held block was terminated by last_i before N_WORDS words arrived.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=FILL, idx=0, m_o=0, mvalid_o=0, len_o=0, short_o=0.
  - ready_o=1 once reset is released.
- States:
  - FILL: collecting words. ready_o=1, mvalid_o=0.
  - FULL: holding a block. ready_o=0, mvalid_o=1.
- ready_o and mvalid_o are decoded purely from state, with no combinational path from any input.
- Word placement:
  - An accepted word (valid_i & ready_o) is written to slot idx.
  - Slot k occupies m_o[256-1-k*WORD_W -: WORD_W], so word 0 goes to bits [255:224].
  - idx then increments.
- FILL -> FULL on an accepted word when idx==N_WORDS-1 or last_i=1.
  - On that edge: len_o=idx+1, short_o=(last_i & idx<N_WORDS-1).
  - m_o and mvalid_o become visible the cycle after the final accepted word (latency 1).
- Zero padding: slots not written keep 0, because the buffer is cleared on every entry to FILL.
- last_i on slot N_WORDS-1 is redundant; short_o=0.
- Words beyond N_WORDS cannot be accepted, since ready_o=0 in FULL. The message boundary is therefore N_WORDS or last_i, whichever comes first.
- FULL -> FILL on consume_i=1.
  - Same edge: idx=0, m_o=0, len_o=0, short_o=0.
  - ready_o=1 the next cycle. There is no same-cycle bypass.
- consume_i while in FILL is ignored.
- valid_i while in FULL is ignored; the word is not lost because ready_o=0.
- clear_i has highest priority, above consume_i and word acceptance.
  - Next state is FILL with idx=0, m_o=0, mvalid_o=0, len_o=0, short_o=0.
  - Any word presented in the same cycle is dropped, even if ready_o=1.
- m_o, len_o and short_o are stable for the entire time mvalid_o=1.
- valid_i may fall without handshake completion. There is no timeout.
- Reset mid-fill or mid-hold: all state returns to reset values immediately; the partial block is lost.

Test Plan:
- Full block: 8 back-to-back words 0x00000001..0x00000008, last_i on word 8, consume_i low -> one cycle after word 8: mvalid_o=1, m_o=0x00000001_00000002_..._00000008, len_o=8, short_o=0, ready_o=0; all hold for 10 idle cycles.
- Short message: words 0xAAAA0000, 0xBBBB1111, 0xCCCC2222 with last_i on the third -> m_o=0xAAAA0000_BBBB1111_CCCC2222 followed by 160 zero bits, len_o=3, short_o=1.
- Backpressure: assert valid_i with word 0xDEADBEEF while FULL for 5 cycles, then pulse consume_i -> ready_o=1 on the next cycle; the word is accepted into slot 0 and m_o is otherwise zero.
- Gapped input: 8 words with valid_i toggling 1/0 on alternate cycles -> same m_o as the back-to-back case; idx advances only on handshake cycles.
- Clear: after 5 words, assert clear_i together with valid_i and word 0x12345678 -> word dropped, mvalid_o stays 0; a following 8-word burst yields a clean block with no residue from the aborted one.
- Async reset while FULL with m_o nonzero: drive rst_ni low mid-cycle -> mvalid_o=0 and m_o=0 without waiting for a clock edge; ready_o=1 after release.

Source files
------------

// File: rtl/aes_msg_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_msg_loader_if : word-stream input and held-block output of the loader  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface aes_msg_loader_if #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 8,
  parameter int CNT_W   = 4
);
  logic                      clear_i;
  logic [WORD_W-1:0]         data_i;
  logic                      valid_i;
  logic                      last_i;
  logic                      ready_o;
  logic                      consume_i;
  logic [WORD_W*N_WORDS-1:0] m_o;
  logic                      mvalid_o;
  logic [CNT_W-1:0]          len_o;
  logic                      short_o;

  modport slave (
    input  clear_i, data_i, valid_i, last_i, consume_i,
    output ready_o, m_o, mvalid_o, len_o, short_o
  );

  modport master (
    output clear_i, data_i, valid_i, last_i, consume_i,
    input  ready_o, m_o, mvalid_o, len_o, short_o
  );
endinterface
`default_nettype wire

// File: rtl/aes_msg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_msg_loader : packs a word stream into a zero-padded 256-bit operand    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module aes_msg_loader #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 8,
  parameter int CNT_W   = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  aes_msg_loader_if.slave bus
);

  localparam int TOTAL_W = WORD_W * N_WORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [TOTAL_W-1:0] m_q, m_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               short_q, short_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    m_d     = m_q;
    len_d   = len_q;
    short_d = short_q;

    // Abort outranks everything, including a word handshake in the same cycle.
    if (bus.clear_i) begin
      state_d = S_FILL;
      idx_d   = '0;
      m_d     = '0;
      len_d   = '0;
      short_d = 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (bus.valid_i) begin
            for (int k = 0; k < N_WORDS; k++) begin
              if (idx_q == CNT_W'(k)) begin
                m_d[TOTAL_W-1-k*WORD_W -: WORD_W] = bus.data_i;
              end
            end
            idx_d = idx_q + CNT_W'(1);
            if ((idx_q == LAST_IDX) || bus.last_i) begin
              state_d = S_FULL;
              len_d   = idx_q + CNT_W'(1);
              short_d = bus.last_i && (idx_q < LAST_IDX);
            end
          end
        end
        S_FULL: begin
          // Buffer is wiped on the way back so unwritten slots read as zero.
          if (bus.consume_i) begin
            state_d = S_FILL;
            idx_d   = '0;
            m_d     = '0;
            len_d   = '0;
            short_d = 1'b0;
          end
        end
        default: begin
          state_d = S_FILL;
          idx_d   = '0;
          m_d     = '0;
          len_d   = '0;
          short_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      m_q     <= '0;
      len_q   <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      len_q   <= len_d;
      short_q <= short_d;
    end
  end

  assign bus.ready_o  = (state_q == S_FILL);
  assign bus.mvalid_o = (state_q == S_FULL);
  assign bus.m_o      = m_q;
  assign bus.len_o    = len_q;
  assign bus.short_o  = short_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_msg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_msg_loader : scoreboard bench with a queue-based message model      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_aes_msg_loader;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 8;
  localparam int CNT_W   = 4;
  localparam int TW      = WORD_W * N_WORDS;

  typedef struct packed {
    logic [TW-1:0]    m;
    logic [CNT_W-1:0] len;
    logic             sh;
  } blk_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_msg_loader_if #(.WORD_W(WORD_W), .N_WORDS(N_WORDS), .CNT_W(CNT_W)) io ();

  aes_msg_loader #(.WORD_W(WORD_W), .N_WORDS(N_WORDS), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (io.slave)
  );

  int total = 0;
  int bad   = 0;

  blk_t        exp_q[$];
  blk_t        held;
  logic        prev_mv = 1'b0;
  logic [31:0] cur[$];
  bit          m_full = 1'b0;

  task automatic chk(string name, logic [TW-1:0] act, logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected operand: received words left-aligned, remainder zero.
  function automatic blk_t make_blk(bit sh);
    blk_t b;
    b.m = '0;
    foreach (cur[i]) b.m = b.m | ({{(TW-WORD_W){1'b0}}, cur[i]} << (TW - WORD_W*(i+1)));
    b.len = CNT_W'(cur.size());
    b.sh  = sh;
    return b;
  endfunction

  // One clock of stimulus; the model advances with what was driven.
  task automatic step(bit v, logic [31:0] d, bit l, bit cons, bit clr);
    chk("ready_o", TW'(io.ready_o), TW'(!m_full));
    chk("mvalid_o", TW'(io.mvalid_o), TW'(m_full));
    io.valid_i   = v;
    io.data_i    = d;
    io.last_i    = l;
    io.consume_i = cons;
    io.clear_i   = clr;
    @(posedge clk);
    if (clr) begin
      cur.delete();
      m_full = 1'b0;
    end else if (!m_full) begin
      if (v) begin
        cur.push_back(d);
        if (cur.size() == N_WORDS || l) begin
          exp_q.push_back(make_blk(l && cur.size() < N_WORDS));
          cur.delete();
          m_full = 1'b1;
        end
      end
    end else if (cons) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic consume();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mv = 1'b0;
    end else begin
      if (io.mvalid_o) begin
        if (!prev_mv) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_block: got %h want none", io.m_o);
            held.m   = io.m_o;
            held.len = io.len_o;
            held.sh  = io.short_o;
          end else begin
            held = exp_q.pop_front();
          end
        end
        chk("block_m", io.m_o, held.m);
        chk("block_len", TW'(io.len_o), TW'(held.len));
        chk("block_short", TW'(io.short_o), TW'(held.sh));
      end else begin
        chk("fill_len", TW'(io.len_o), TW'(0));
        chk("fill_short", TW'(io.short_o), TW'(0));
      end
      prev_mv = io.mvalid_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    io.valid_i   = 1'b0;
    io.data_i    = '0;
    io.last_i    = 1'b0;
    io.consume_i = 1'b0;
    io.clear_i   = 1'b0;
    #1;
    chk("rst_mvalid", TW'(io.mvalid_o), TW'(0));
    chk("rst_m", io.m_o, '0);
    chk("rst_len", TW'(io.len_o), TW'(0));
    chk("rst_short", TW'(io.short_o), TW'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full back-to-back block, held for 10 idle cycles.
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), i == 8, 1'b0, 1'b0);
    idle(10);
    consume();
    idle(1);

    // Short message.
    step(1'b1, 32'hAAAA0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hBBBB1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hCCCC2222, 1'b1, 1'b0, 1'b0);
    idle(3);
    consume();

    // Backpressure while FULL, then the same word lands in slot 0.
    step(1'b1, 32'h00000005, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    idle(2);
    consume();

    // Gapped input.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), i == 8, 1'b0, 1'b0);
      step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    end
    consume();

    // Clear after 5 words, then a clean burst.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1);
    idle(2);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    idle(2);
    consume();

    // Asynchronous reset while holding a nonzero block.
    for (int i = 0; i < 8; i++) step(1'b1, $urandom | 32'h1, 1'b0, 1'b0, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mvalid", TW'(io.mvalid_o), TW'(0));
    chk("arst_m", io.m_o, '0);
    chk("arst_len", TW'(io.len_o), TW'(0));
    cur.delete();
    m_full = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_blocks: got %0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
